// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
//
// Main control FSM for a multicycle MIPS-style datapath. It steps each
// instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK phases
// chosen by the opcode. It stalls on memory through a mem_ready handshake and
// drives every datapath mux select and write strobe.
//
// Parameters
//   USE_MEM_READY  1: FETCH/MEMRD/MEMWR wait for mem_ready
//                  0: mem_ready is ignored and treated as always 1
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset (returns to FETCH)
//   opcode[5:0]    instr[31:26] from IR, looked at in DECODE and MEMADR only
//   mem_ready      memory access completes this cycle
//   pc_write       unconditional PC write
//   pc_write_cond  PC write qualified by ALU zero (beq)
//   i_or_d         memory address select: 0 PC, 1 ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       load instruction register
//   mem_to_reg     writeback data select: 1 MDR, 0 ALUOut
//   reg_dst        destination register select: 1 rd, 0 rt
//   reg_write      register file write
//   alu_src_a      ALU A select: 0 PC, 1 rs
//   alu_src_b[1:0] ALU B select: 00 rt, 01 4, 10 sext imm, 11 sext imm<<2
//   alu_op[1:0]    00 add, 01 sub, 10 decode funct
//   pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   state[3:0]     current state code (debug)
//   instr_done     one-cycle pulse in the last state of each legal instruction
//   illegal_op     high in DECODE when the opcode is not supported
// -----------------------------------------------------------------------------
module multicycle_main_control #(
  parameter int unsigned USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q, state_d;

  // Effective handshake: with the handshake disabled every wait state
  // completes in a single cycle.
  logic mem_ok;
  assign mem_ok = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+4 commit only on the cycle the fetch completes.
        ir_write  = mem_ok;
        pc_write  = mem_ok;
        state_d   = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ok ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // mem_write stays asserted for the whole stall.
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ok;
        state_d    = mem_ok ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        // Unused codes 12-15 recover to FETCH with all strobes low.
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  logic [5:0] opcode2 = 6'h3f;
  logic       mem_ready2 = 1'b0;
  logic       pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2;
  logic       mem_to_reg2, reg_dst2, reg_write2, alu_src_a2, instr_done2, illegal_op2;
  logic [1:0] alu_src_b2, alu_op2, pc_source2;
  logic [3:0] state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_main_control #(.USE_MEM_READY(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  multicycle_main_control #(.USE_MEM_READY(0)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode2), .mem_ready(mem_ready2),
    .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .i_or_d(i_or_d2),
    .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
    .mem_to_reg(mem_to_reg2), .reg_dst(reg_dst2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .pc_source(pc_source2), .state(state2), .instr_done(instr_done2),
    .illegal_op(illegal_op2)
  );

  logic [17:0] word, word2;
  assign word  = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal_op};
  assign word2 = {pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2,
                  mem_to_reg2, reg_dst2, reg_write2, alu_src_a2, alu_src_b2, alu_op2,
                  pc_source2, instr_done2, illegal_op2};

  // One expected cycle: state the DUT should be in, inputs to drive, and
  // whether DECODE should flag the opcode.
  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic [5:0] opc;
    logic       ill;
  } ent_t;

  ent_t exp_q[$];

  // Control word the spec's state table prescribes.
  function automatic logic [17:0] ctrl(input logic [3:0] st, input logic mr, input logic ill);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, done, il;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, done, il} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  begin asb = 2'b11; il = ill; end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mwr = 1; iod = 1; done = mr; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; done = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      4'd9:  begin pw = 1; psrc = 2'b10; done = 1; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, done, il};
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
           o == 6'b000100 || o == 6'b000010 || o == 6'b001000;
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] opc, input logic ill);
    ent_t e;
    e.st = st; e.mr = mr; e.opc = opc; e.ill = ill;
    exp_q.push_back(e);
  endtask

  // Instruction-level model: the sequence of phases each opcode passes
  // through, with the requested number of stall cycles in the memory phases.
  // mem_ready is randomised wherever the spec says it is irrelevant, and the
  // opcode carries junk wherever it is not looked at.
  task automatic build(input logic [5:0] opc, input int fstall, input int mstall);
    bit ill;
    ill = !is_legal(opc);
    repeat (fstall) push(4'd0, 1'b0, junk(), 1'b0);
    push(4'd0, 1'b1, junk(), 1'b0);
    push(4'd1, 1'($urandom), opc, ill);
    case (opc)
      6'b000000: begin push(4'd6, 1'($urandom), junk(), 0); push(4'd7, 1'($urandom), junk(), 0); end
      6'b100011: begin
        push(4'd2, 1'($urandom), opc, 0);
        repeat (mstall) push(4'd3, 1'b0, junk(), 0);
        push(4'd3, 1'b1, junk(), 0);
        push(4'd4, 1'($urandom), junk(), 0);
      end
      6'b101011: begin
        push(4'd2, 1'($urandom), opc, 0);
        repeat (mstall) push(4'd5, 1'b0, junk(), 0);
        push(4'd5, 1'b1, junk(), 0);
      end
      6'b000100: push(4'd8, 1'($urandom), junk(), 0);
      6'b000010: push(4'd9, 1'($urandom), junk(), 0);
      6'b001000: begin push(4'd10, 1'($urandom), junk(), 0); push(4'd11, 1'($urandom), junk(), 0); end
      default: ;
    endcase
  endtask

  task automatic drive(input ent_t e);
    @(negedge clk);
    opcode    = e.opc;
    mem_ready = e.mr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state, word} !== {4'd0, ctrl(4'd0, 1'b0, 1'b0)}) begin
      errors++;
      $display("FAIL reset st=%0d word=%h exp st=0 word=%h", state, word, ctrl(4'd0, 1'b0, 1'b0));
    end
    checks++;
    if ({state2, word2} !== {4'd0, ctrl(4'd0, 1'b1, 1'b0)}) begin
      errors++;
      $display("FAIL reset_nomr st=%0d word=%h exp st=0 word=%h", state2, word2, ctrl(4'd0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_rtype();
    ent_t e;
    build(6'b000000, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      checks++;
      if ({state, word} !== {e.st, ctrl(e.st, e.mr, e.ill)}) begin
        errors++;
        $display("FAIL rtype st=%0d word=%h exp st=%0d word=%h", state, word, e.st, ctrl(e.st, e.mr, e.ill));
      end
    end
  endtask

  task automatic test_lw_stall();
    ent_t e;
    build(6'b100011, 0, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      checks++;
      if ({state, word} !== {e.st, ctrl(e.st, e.mr, e.ill)}) begin
        errors++;
        $display("FAIL lw_stall st=%0d word=%h exp st=%0d word=%h", state, word, e.st, ctrl(e.st, e.mr, e.ill));
      end
    end
  endtask

  task automatic test_branch_jump_addi();
    ent_t e;
    build(6'b000100, 0, 0);
    build(6'b000010, 1, 0);
    build(6'b001000, 0, 0);
    build(6'b101011, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      checks++;
      if ({state, word} !== {e.st, ctrl(e.st, e.mr, e.ill)}) begin
        errors++;
        $display("FAIL beq_j_addi_sw st=%0d word=%h exp st=%0d word=%h", state, word, e.st, ctrl(e.st, e.mr, e.ill));
      end
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    build(6'b111111, 0, 0);
    build(6'b000001, 0, 0);
    build(6'b000000, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      checks++;
      if ({state, word} !== {e.st, ctrl(e.st, e.mr, e.ill)}) begin
        errors++;
        $display("FAIL illegal st=%0d word=%h exp st=%0d word=%h", state, word, e.st, ctrl(e.st, e.mr, e.ill));
      end
    end
  endtask

  task automatic test_fetch_stall();
    ent_t e;
    build(6'b001000, 3, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      checks++;
      if ({state, word} !== {e.st, ctrl(e.st, e.mr, e.ill)}) begin
        errors++;
        $display("FAIL fetch_stall st=%0d word=%h exp st=%0d word=%h", state, word, e.st, ctrl(e.st, e.mr, e.ill));
      end
    end
  endtask

  task automatic test_reset_in_memwr();
    ent_t e;
    int seen_wr;
    seen_wr = 0;
    build(6'b101011, 0, 6);
    while (exp_q.size() > 0 && seen_wr < 2) begin
      e = exp_q.pop_front();
      drive(e);
      if (e.st == 4'd5) seen_wr++;
      checks++;
      if ({state, word} !== {e.st, ctrl(e.st, e.mr, e.ill)}) begin
        errors++;
        $display("FAIL sw_pre_reset st=%0d word=%h exp st=%0d word=%h", state, word, e.st, ctrl(e.st, e.mr, e.ill));
      end
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({state, word} !== {4'd0, ctrl(4'd0, 1'b0, 1'b0)}) begin
      errors++;
      $display("FAIL reset_memwr st=%0d word=%h exp st=0 word=%h", state, word, ctrl(4'd0, 1'b0, 1'b0));
    end
    build(6'b101011, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      checks++;
      if ({state, word} !== {e.st, ctrl(e.st, e.mr, e.ill)}) begin
        errors++;
        $display("FAIL sw_after_reset st=%0d word=%h exp st=%0d word=%h", state, word, e.st, ctrl(e.st, e.mr, e.ill));
      end
    end
  endtask

  task automatic test_random();
    ent_t e;
    logic [5:0] legal [6];
    logic [5:0] opc;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7) == 0) begin
        do opc = junk(); while (is_legal(opc));
      end else begin
        opc = legal[$urandom_range(5)];
      end
      build(opc, $urandom_range(2), $urandom_range(3));
    end
    push(4'd0, 1'b0, junk(), 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive(e);
      checks++;
      if ({state, word} !== {e.st, ctrl(e.st, e.mr, e.ill)}) begin
        errors++;
        $display("FAIL random st=%0d word=%h exp st=%0d word=%h", state, word, e.st, ctrl(e.st, e.mr, e.ill));
      end
    end
  endtask

  // Handshake disabled: the second instance sees mem_ready=0 throughout and
  // must still leave every wait state after one cycle.
  task automatic test_no_mem_ready();
    logic [3:0] path [10];
    logic [5:0] opcs [10];
    path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    opcs = '{6'h00, 6'b100011, 6'b100011, 6'h00, 6'h00, 6'h00, 6'b101011, 6'b101011, 6'h00, 6'h00};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      opcode2    = opcs[i];
      mem_ready2 = 1'b0;
      mem_ready  = 1'b0;
      #1;
      checks++;
      if ({state2, word2} !== {path[i], ctrl(path[i], 1'b1, 1'b0)}) begin
        errors++;
        $display("FAIL no_mem_ready cyc=%0d st=%0d word=%h exp st=%0d word=%h",
                 i, state2, word2, path[i], ctrl(path[i], 1'b1, 1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch_jump_addi();
    test_illegal();
    test_fetch_stall();
    test_reset_in_memwr();
    test_random();
    test_no_mem_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
